// File: rtl/amba_axi4_lite_pkg.sv
// Shared types for the AXI4-Lite single-outstanding master.
// Response codes and master FSM states.
package amba_axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } master_state_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/amba_axi4_lite_master_if.sv
// AXI4-Lite bus bundle between one master and one slave.
interface amba_axi4_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/amba_axi4_lite_master.sv
// Purpose: turns single user commands into AXI4-Lite read/write transactions, one outstanding.
// Latency: 4 cycles from command acceptance to o_rsp_valid with a zero-wait slave.
// Backpressure: o_cmd_ready only in IDLE; AXI VALIDs held until their READY, registered outputs.
module amba_axi4_lite_master
  import amba_axi4_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  amba_axi4_lite_master_if.master         m_axi,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_cmd_strb,
  output logic                            o_rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]                      o_rsp_resp
);

  master_state_e                   state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                            bready_q, bready_d, arvalid_q, arvalid_d;
  logic                            rready_q, rready_d, rsp_valid_q, rsp_valid_d;
  axi_resp_e                       rsp_resp_q, rsp_resp_d;
  logic                            aw_done, w_done;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Every output register is loaded from its next value so nothing on the bus is combinational.
  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    aw_done    = 1'b0;
    w_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          if (i_cmd_we) begin
            state_d   = WR;
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            araddr_d  = i_cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W complete independently, in either order or together.
        aw_done = !awvalid_q || m_axi.M_AXI_AWREADY;
        w_done  = !wvalid_q  || m_axi.M_AXI_WREADY;
        if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          state_d    = DONE;
          bready_d   = 1'b0;
          rsp_data_d = '0;
          rsp_resp_d = axi_resp_e'(m_axi.M_AXI_BRESP);
        end
      end
      RD_ADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_axi.M_AXI_RVALID) begin
          state_d    = DONE;
          rready_d   = 1'b0;
          rsp_data_d = m_axi.M_AXI_RDATA;
          rsp_resp_d = axi_resp_e'(m_axi.M_AXI_RRESP);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_resp  = rsp_resp_q;

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_amba_axi4_lite_master.sv
// Bench for amba_axi4_lite_master: configurable-delay slave, response scoreboard, scenario tasks.
module tb_amba_axi4_lite_master;
  import amba_axi4_lite_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;

  always #5 clk = ~clk;

  amba_axi4_lite_master_if #(.ADDR_W(32), .DATA_W(32)) axi();

  amba_axi4_lite_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32)) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .m_axi       (axi.master),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_we    (cmd_we),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .i_cmd_strb  (cmd_strb),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_resp  (rsp_resp)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  // slave configuration and observation
  int          aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  int          aw_cnt, w_cnt, b_cnt, r_cnt;
  bit          aw_done, w_done, ar_done;
  bit          awvalid_p, wvalid_p, arvalid_p, bready_p, rready_p;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_pulses = 0;
  bit          split_seen, rready_gap;
  logic [31:0] hs_awaddr, hs_wdata, hs_araddr;
  logic [3:0]  hs_wstrb;

  // Slave acts on falling edges; *_p hold the DUT outputs that were present at the last rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_BVALID = 1'b0; axi.M_AXI_BRESP = 2'b00;
        axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = '0; axi.M_AXI_RRESP = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
      end else begin
        if (axi.M_AXI_AWREADY && awvalid_p) begin
          axi.M_AXI_AWREADY = 1'b0; aw_done = 1'b1; aw_hs++; aw_cnt = 0;
        end else if (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) begin
          if (aw_cnt >= aw_dly) begin axi.M_AXI_AWREADY = 1'b1; hs_awaddr = axi.M_AXI_AWADDR; end
          else aw_cnt++;
        end
        if (axi.M_AXI_WREADY && wvalid_p) begin
          axi.M_AXI_WREADY = 1'b0; w_done = 1'b1; w_hs++; w_cnt = 0;
        end else if (axi.M_AXI_WVALID && !axi.M_AXI_WREADY) begin
          if (w_cnt >= w_dly) begin
            axi.M_AXI_WREADY = 1'b1; hs_wdata = axi.M_AXI_WDATA; hs_wstrb = axi.M_AXI_WSTRB;
          end else w_cnt++;
        end
        if (axi.M_AXI_BVALID && bready_p) begin
          axi.M_AXI_BVALID = 1'b0; b_hs++; aw_done = 1'b0; w_done = 1'b0; b_cnt = 0;
        end else if (aw_done && w_done && !axi.M_AXI_BVALID) begin
          if (b_cnt >= b_dly) begin axi.M_AXI_BVALID = 1'b1; axi.M_AXI_BRESP = b_resp_cfg; end
          else b_cnt++;
        end
        if (axi.M_AXI_ARREADY && arvalid_p) begin
          axi.M_AXI_ARREADY = 1'b0; ar_done = 1'b1; ar_hs++;
        end else if (axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY) begin
          axi.M_AXI_ARREADY = 1'b1; hs_araddr = axi.M_AXI_ARADDR;
        end
        if (axi.M_AXI_RVALID && rready_p) begin
          axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = '0; r_hs++; ar_done = 1'b0; r_cnt = 0;
        end else if (ar_done && !axi.M_AXI_RVALID) begin
          if (!axi.M_AXI_RREADY) rready_gap = 1'b1;
          if (r_cnt >= r_dly) begin
            axi.M_AXI_RVALID = 1'b1; axi.M_AXI_RDATA = r_data_cfg; axi.M_AXI_RRESP = r_resp_cfg;
          end else r_cnt++;
        end
        if (axi.M_AXI_AWVALID !== axi.M_AXI_WVALID) split_seen = 1'b1;
      end
      awvalid_p = axi.M_AXI_AWVALID; wvalid_p = axi.M_AXI_WVALID; arvalid_p = axi.M_AXI_ARVALID;
      bready_p = axi.M_AXI_BREADY; rready_p = axi.M_AXI_RREADY;
    end
  end

  // Scoreboard: every response pulse is matched against the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid === 1'b1) begin
        rsp_pulses++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: got data=%h resp=%0d, required no response", rsp_data, rsp_resp);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_data, rsp_resp} !== {e.data, e.resp}) begin
            fails++;
            $display("FAIL rsp_payload: got data=%h resp=%0d, required data=%h resp=%0d",
                     rsp_data, rsp_resp, e.data, e.resp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // Issues one command from a falling edge; lat counts the acceptance cycle as 1 up to the pulse cycle.
  task automatic do_cmd(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [31:0] edata, input logic [1:0] eresp,
                        output int lat);
    int n;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_strb = strb;
    exp_q.push_back('{data: edata, resp: eresp});
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: o_cmd_ready stayed %b, required 1", cmd_ready);
      cmd_valid = 1'b0; lat = -1;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 2;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: no o_rsp_valid, required a response");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID, axi.M_AXI_BREADY,
         axi.M_AXI_RREADY, rsp_valid, cmd_ready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_handshake: got %b, required 0000000", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID,
               axi.M_AXI_ARVALID, axi.M_AXI_BREADY, axi.M_AXI_RREADY, rsp_valid, cmd_ready});
    end
    tests++;
    if ({axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_WSTRB, axi.M_AXI_ARADDR, rsp_data, rsp_resp,
         axi.M_AXI_AWPROT, axi.M_AXI_ARPROT} !== '0) begin
      fails++;
      $display("FAIL reset_payload: got awaddr=%h wdata=%h araddr=%h rsp=%h/%0d, required all 0",
               axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_ARADDR, rsp_data, rsp_resp);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write_basic();
    int lat, a0, w0, b0;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs;
    b_resp_cfg = 2'b00;
    do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, lat);
    tests++;
    if (lat != 4) begin fails++; $display("FAIL write_latency: got %0d, required 4", lat); end
    repeat (2) @(negedge clk);
    tests++;
    if ({aw_hs - a0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1}) begin
      fails++; $display("FAIL write_beats: got aw=%0d w=%0d b=%0d, required 1 1 1", aw_hs - a0, w_hs - w0, b_hs - b0);
    end
    tests++;
    if ({hs_awaddr, hs_wdata, hs_wstrb} !== {32'h4, 32'hDEADBEEF, 4'hF}) begin
      fails++; $display("FAIL write_payload: got %h %h %h, required 00000004 deadbeef f", hs_awaddr, hs_wdata, hs_wstrb);
    end
  endtask

  task automatic test_write_delays();
    int lat, a0, w0, b0, p0;
    for (int order = 0; order < 2; order++) begin
      aw_dly = (order == 0) ? 3 : 0;
      w_dly  = (order == 0) ? 0 : 3;
      split_seen = 1'b0;
      a0 = aw_hs; w0 = w_hs; b0 = b_hs; p0 = rsp_pulses;
      do_cmd(1'b1, 32'h40 + 32'(order), 32'hA5A50000 + 32'(order), 4'h3, 32'h0, 2'b00, lat);
      repeat (3) @(negedge clk);
      tests++;
      if (lat != 7) begin fails++; $display("FAIL delay_latency[%0d]: got %0d, required 7", order, lat); end
      tests++;
      if (split_seen !== 1'b1) begin
        fails++; $display("FAIL delay_independent_drop[%0d]: got %b, required 1", order, split_seen);
      end
      tests++;
      if ({aw_hs - a0, w_hs - w0, b_hs - b0, rsp_pulses - p0} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
        fails++; $display("FAIL delay_counts[%0d]: got aw=%0d w=%0d b=%0d rsp=%0d, required 1 1 1 1",
                          order, aw_hs - a0, w_hs - w0, b_hs - b0, rsp_pulses - p0);
      end
    end
    aw_dly = 0; w_dly = 0;
  endtask

  task automatic test_read_delay();
    int lat;
    r_dly = 5; r_data_cfg = 32'h12345678; r_resp_cfg = 2'b00; rready_gap = 1'b0;
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 32'h12345678, 2'b00, lat);
    tests++;
    if (lat != 9) begin fails++; $display("FAIL read_latency: got %0d, required 9", lat); end
    tests++;
    if (rready_gap !== 1'b0) begin fails++; $display("FAIL read_rready_held: got gap=%b, required 0", rready_gap); end
    tests++;
    if (hs_araddr !== 32'h8) begin fails++; $display("FAIL read_addr: got %h, required 00000008", hs_araddr); end
    r_dly = 0;
  endtask

  task automatic test_slverr_then_next();
    int lat;
    b_resp_cfg = SLVERR;
    do_cmd(1'b1, 32'h100, 32'h55AA55AA, 4'hF, 32'h0, 2'b10, lat);
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL done_not_ready: got %b, required 0", cmd_ready); end
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_ready_after_done: got %b, required 1", cmd_ready); end
    b_resp_cfg = OKAY; r_data_cfg = 32'hCAFEF00D; r_resp_cfg = OKAY;
    do_cmd(1'b0, 32'h104, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00, lat);
    tests++;
    if (lat != 4) begin fails++; $display("FAIL next_read_latency: got %0d, required 4", lat); end
  endtask

  task automatic test_resp_codes();
    int lat;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom; r_data_cfg = d; r_resp_cfg = 2'(i);
      do_cmd(1'b0, 32'(i * 4), 32'h0, 4'h0, d, 2'(i), lat);
      tests++;
      if (lat != 4) begin fails++; $display("FAIL rd_code_latency[%0d]: got %0d, required 4", i, lat); end
      b_resp_cfg = 2'(3 - i);
      do_cmd(1'b1, 32'h200 + 32'(i * 4), $urandom, 4'(i + 1), 32'h0, 2'(3 - i), lat);
    end
    b_resp_cfg = OKAY; r_resp_cfg = OKAY;
  endtask

  task automatic test_busy_ignored();
    int n, a0;
    bit aw_early;
    r_dly = 6; r_data_cfg = 32'h0BADF00D; aw_early = 1'b0; a0 = aw_hs;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h20;
    exp_q.push_back('{data: 32'h0BADF00D, resp: 2'b00});
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_we = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h11112222; cmd_strb = 4'hF;
    exp_q.push_back('{data: 32'h0, resp: 2'b00});
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      if (axi.M_AXI_AWVALID === 1'b1) aw_early = 1'b1;
      @(negedge clk); n++;
    end
    tests++;
    if (aw_early !== 1'b0 || n >= 60) begin
      fails++; $display("FAIL busy_ignored: got aw_early=%b wait=%0d, required 0 and a read response", aw_early, n);
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (aw_hs - a0 != 1 || n >= 50) begin
      fails++; $display("FAIL busy_then_accepted: got aw=%0d wait=%0d, required 1 handshake", aw_hs - a0, n);
    end
    r_dly = 0;
  endtask

  task automatic test_reset_mid();
    int n, p0, a0;
    aw_dly = 1000; p0 = rsp_pulses;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h300; cmd_wdata = 32'h77; cmd_strb = 4'h1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_AWREADY} !== 2'b10) begin
      fails++; $display("FAIL midreset_precond: got awvalid/awready=%b%b, required 10", axi.M_AXI_AWVALID, axi.M_AXI_AWREADY);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_AWADDR, axi.M_AXI_WDATA,
         axi.M_AXI_WSTRB, rsp_valid, cmd_ready} !== '0) begin
      fails++; $display("FAIL midreset_async_clear: got awv=%b wv=%b awaddr=%h wdata=%h rdy=%b, required all 0",
                        axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_AWADDR, axi.M_AXI_WDATA, cmd_ready);
    end
    @(negedge clk);
    aw_dly = 0;
    #2 rst = 1'b0;
    a0 = aw_hs;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b, required 1", cmd_ready); end
    repeat (10) @(negedge clk);
    tests++;
    if (rsp_pulses != p0 || aw_hs != a0) begin
      fails++; $display("FAIL midreset_no_rsp: got pulses=%0d aw=%0d, required none", rsp_pulses - p0, aw_hs - a0);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_delays();
    test_read_delay();
    test_slverr_then_next();
    test_resp_codes();
    test_busy_ignored();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
